// File: rtl/po_fpga_job_dispatcher.sv
// Batch job dispatcher: a job FIFO feeding NUM_CORES simulation cores round-robin,
// with a go/done handshake, a per-core timeout watchdog and batch-complete signalling.
module po_fpga_job_dispatcher #(
  parameter int NUM_CORES = 4,
  parameter int ROWS_W    = 5,
  parameter int CONES_W   = 4,
  parameter int QDEPTH    = 8,
  parameter int TIMEOUT_W = 24
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         go_i,
  input  logic                         job_valid,
  output logic                         job_ready,
  input  logic [ROWS_W-1:0]            job_rows,
  input  logic [CONES_W-1:0]           job_cones,
  input  logic [TIMEOUT_W-1:0]         timeout_limit,
  output logic [NUM_CORES-1:0]         core_go,
  output logic [NUM_CORES*ROWS_W-1:0]  core_rows,
  output logic [NUM_CORES*CONES_W-1:0] core_cones,
  input  logic [NUM_CORES-1:0]         core_done,
  output logic [NUM_CORES-1:0]         core_abort,
  output logic                         busy,
  output logic                         done,
  output logic [15:0]                  jobs_done,
  output logic [NUM_CORES-1:0]         err_mask
);
  localparam int IDX_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
  localparam int PTR_W = $clog2(QDEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(QDEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t                      r_state;
  logic [ROWS_W-1:0]           r_fifo_rows  [QDEPTH];
  logic [CONES_W-1:0]          r_fifo_cones [QDEPTH];
  logic [PTR_W-1:0]            r_wr_ptr;
  logic [PTR_W-1:0]            r_rd_ptr;
  logic [CNT_W-1:0]            r_count;
  logic                        r_job_ready;
  logic [NUM_CORES-1:0]        r_core_busy;
  logic [TIMEOUT_W-1:0]        r_wd [NUM_CORES];
  logic [IDX_W-1:0]            r_rr_ptr;
  logic [NUM_CORES-1:0]        r_core_go;
  logic [NUM_CORES-1:0]        r_core_abort;
  logic [NUM_CORES*ROWS_W-1:0] r_core_rows;
  logic [NUM_CORES*CONES_W-1:0] r_core_cones;
  logic                        r_busy;
  logic                        r_done;
  logic [15:0]                 r_jobs_done;
  logic [NUM_CORES-1:0]        r_err_mask;

  logic                        w_push;
  logic                        w_dispatch;
  logic                        w_clear;
  logic                        w_found;
  logic                        w_hit;
  logic [IDX_W-1:0]            w_sel;
  logic [IDX_W-1:0]            w_cand;
  logic [IDX_W:0]              w_sum;
  logic [CNT_W-1:0]            w_count_next;
  logic [NUM_CORES-1:0]        w_timeout;
  logic [NUM_CORES-1:0]        w_retire;
  logic [3:0]                  w_retire_cnt;
  logic [16:0]                 w_jobs_sum;

  assign w_push       = job_valid && r_job_ready;
  assign w_dispatch   = (r_state == S_RUN) && (r_count != '0) && w_found;
  assign w_clear      = (r_state == S_IDLE) && go_i;
  assign w_count_next = r_count + CNT_W'(w_push) - CNT_W'(w_dispatch);
  assign w_retire     = (core_done & r_core_busy) | w_timeout;
  assign w_jobs_sum   = {1'b0, r_jobs_done} + 17'(w_retire_cnt);

  // First free core at or after the round-robin pointer, wrapping at NUM_CORES
  always_comb begin
    w_found = 1'b0;
    w_hit   = 1'b0;
    w_sel   = '0;
    w_sum   = '0;
    w_cand  = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      w_sum   = {1'b0, r_rr_ptr} + (IDX_W+1)'(i);
      w_sum   = (w_sum >= (IDX_W+1)'(NUM_CORES)) ? (w_sum - (IDX_W+1)'(NUM_CORES)) : w_sum;
      w_cand  = w_sum[IDX_W-1:0];
      w_hit   = !w_found && !r_core_busy[w_cand];
      w_sel   = w_hit ? w_cand : w_sel;
      w_found = w_found | w_hit;
    end
  end

  // Watchdog expiry per core; a same-cycle completion takes precedence
  always_comb begin
    w_timeout = '0;
    for (int k = 0; k < NUM_CORES; k++) begin
      w_timeout[k] = r_core_busy[k] && !core_done[k] && (timeout_limit != '0) &&
                     ((r_wd[k] + TIMEOUT_W'(1)) == timeout_limit);
    end
  end

  // Number of runs retired this cycle (completions plus timeouts)
  always_comb begin
    w_retire_cnt = 4'd0;
    for (int k = 0; k < NUM_CORES; k++) begin
      w_retire_cnt = w_retire_cnt + {3'b000, w_retire[k]};
    end
  end

  // FIFO storage, written on an accepted push
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_rows[r_wr_ptr]  <= job_rows;
      r_fifo_cones[r_wr_ptr] <= job_cones;
    end
  end

  // FIFO pointers, occupancy and registered ready
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_job_ready <= 1'b1;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_dispatch) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      r_count     <= w_count_next;
      r_job_ready <= (w_count_next != FULL_CNT);
    end
  end

  // Batch FSM with registered busy/done and round-robin pointer
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= S_IDLE;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_rr_ptr <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (go_i) begin
            r_state <= S_RUN;
            r_busy  <= 1'b1;
          end
        end
        S_RUN: begin
          if (w_dispatch) begin
            r_rr_ptr <= (w_sel == IDX_W'(NUM_CORES-1)) ? '0 : (w_sel + IDX_W'(1));
          end else if (r_count == '0) begin
            r_state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (r_count != '0) begin
            r_state <= S_RUN;
          end else if (r_core_busy == '0) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  // Per-core dispatch, completion, watchdog and go/abort pulses
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_core_busy  <= '0;
      r_core_go    <= '0;
      r_core_abort <= '0;
      r_core_rows  <= '0;
      r_core_cones <= '0;
      for (int k = 0; k < NUM_CORES; k++) r_wd[k] <= '0;
    end else begin
      for (int k = 0; k < NUM_CORES; k++) begin
        r_core_go[k]    <= 1'b0;
        r_core_abort[k] <= 1'b0;
        if (w_dispatch && (w_sel == IDX_W'(k))) begin
          r_core_busy[k] <= 1'b1;
          r_core_go[k]   <= 1'b1;
          r_wd[k]        <= '0;
          r_core_rows[k*ROWS_W +: ROWS_W]    <= r_fifo_rows[r_rd_ptr];
          r_core_cones[k*CONES_W +: CONES_W] <= r_fifo_cones[r_rd_ptr];
        end else if (r_core_busy[k]) begin
          if (core_done[k]) begin
            r_core_busy[k] <= 1'b0;
          end else if (w_timeout[k]) begin
            r_core_busy[k]  <= 1'b0;
            r_core_abort[k] <= 1'b1;
          end else begin
            r_wd[k] <= r_wd[k] + TIMEOUT_W'(1);
          end
        end
      end
    end
  end

  // Batch statistics, cleared when a new batch starts
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_jobs_done <= '0;
      r_err_mask  <= '0;
    end else if (w_clear) begin
      r_jobs_done <= '0;
      r_err_mask  <= '0;
    end else begin
      r_jobs_done <= w_jobs_sum[16] ? 16'hFFFF : w_jobs_sum[15:0];
      r_err_mask  <= r_err_mask | w_timeout;
    end
  end

  assign job_ready  = r_job_ready;
  assign core_go    = r_core_go;
  assign core_abort = r_core_abort;
  assign core_rows  = r_core_rows;
  assign core_cones = r_core_cones;
  assign busy       = r_busy;
  assign done       = r_done;
  assign jobs_done  = r_jobs_done;
  assign err_mask   = r_err_mask;

endmodule
